// File: rtl/glb_port_arbiter_pkg.sv
// rtl/glb_port_arbiter_pkg.sv - shared types and codes for the GLB port arbiter
package glb_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   localparam int REQ_WEIGHT = 0;
   localparam int REQ_IFMAP  = 1;
   localparam int REQ_IPSUM  = 2;
   localparam int REQ_OPSUM  = 3;

   localparam logic [1:0] LOAD_1BYTE = 2'd0;
   localparam logic [1:0] LOAD_2BYTE = 2'd1;
   localparam logic [1:0] LOAD_3BYTE = 2'd2;
   localparam logic [1:0] LOAD_4BYTE = 2'd3;

endpackage

// File: rtl/glb_port_arbiter_if.sv
// rtl/glb_port_arbiter_if.sv - requester and GLB-side signal bundle of the GLB port arbiter
interface glb_port_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]             req_i;
   logic [NUM_REQ-1:0]             last_i;
   logic [NUM_REQ-1:0][3:0]        web_i;
   logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
   logic [NUM_REQ-1:0][1:0]        byte_type_i;
   logic [NUM_REQ-1:0][DATA_W-1:0] wdata_i;
   logic [NUM_REQ-1:0]             gnt_o;
   logic [NUM_REQ-1:0]             rvalid_o;
   logic [DATA_W-1:0]              rdata_o;
   logic                           glb_en_o;
   logic [3:0]                     glb_web_o;
   logic [ADDR_W-1:0]              glb_addr_o;
   logic [1:0]                     glb_byte_type_o;
   logic [DATA_W-1:0]              glb_wdata_o;
   logic [DATA_W-1:0]              glb_rdata_i;
   logic                           busy_o;

   modport slave (
      input  req_i, last_i, web_i, addr_i, byte_type_i, wdata_i, glb_rdata_i,
      output gnt_o, rvalid_o, rdata_o, glb_en_o, glb_web_o, glb_addr_o,
             glb_byte_type_o, glb_wdata_o, busy_o
   );

   modport master (
      output req_i, last_i, web_i, addr_i, byte_type_i, wdata_i, glb_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, glb_en_o, glb_web_o, glb_addr_o,
             glb_byte_type_o, glb_wdata_o, busy_o
   );
endinterface

// File: rtl/glb_port_arbiter_rr_pick.sv
// rtl/glb_port_arbiter_rr_pick.sv - combinational round-robin picker, first set request at or after i_start
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_start,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_idx,
   output logic               o_any
);
   int               w_sum;
   logic [PTR_W-1:0] w_k;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_sum = 0;
      w_k   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sum = int'(i_start) + i;
         if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
         w_k = PTR_W'(w_sum);
         if (!o_any && i_req[w_k]) begin
            o_any      = 1'b1;
            o_idx      = w_k;
            o_gnt[w_k] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/glb_port_arbiter.sv
// rtl/glb_port_arbiter.sv - burst-granular round-robin arbiter for the shared GLB SRAM port
// GLB_ARB_PERF_EN adds per-requester wait/beat counters with perf_clr_i.
module glb_port_arbiter
   import glb_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   glb_port_arbiter_if.slave bus
`ifdef GLB_ARB_PERF_EN
   ,
   input  logic                     perf_clr_i,
   output logic [NUM_REQ-1:0][15:0] perf_wait_o,
   output logic [NUM_REQ-1:0][15:0] perf_beat_o
`endif
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e         r_state;
   logic [PTR_W-1:0]   r_own;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   r_rd_tag;
   logic [NUM_REQ-1:0] r_gnt;
   logic               r_rd_pend;

   logic               w_beat;
   logic               w_any;
   logic [PTR_W-1:0]   w_own_nxt;
   logic [PTR_W-1:0]   w_start;
   logic [PTR_W-1:0]   w_pick_idx;
   logic [NUM_REQ-1:0] w_pick_req;
   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [NUM_REQ-1:0] w_rvalid;
   logic [3:0]         w_web;
   logic [ADDR_W-1:0]  w_addr;
   logic [1:0]         w_bt;
   logic [DATA_W-1:0]  w_wdata;

   assign w_beat    = (r_state == BURST) && bus.req_i[r_own];
   assign w_own_nxt = (r_own == PTR_W'(NUM_REQ - 1)) ? '0 : r_own + 1'b1;

   // At burst end the owner is masked out so it only wins again via IDLE.
   always_comb begin
      w_pick_req = bus.req_i;
      w_start    = r_rr_ptr;
      if (r_state == BURST) begin
         w_pick_req = bus.req_i & ~r_gnt;
         w_start    = w_own_nxt;
      end
   end

   rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_pick (
      .i_req   (w_pick_req),
      .i_start (w_start),
      .o_gnt   (w_pick_gnt),
      .o_idx   (w_pick_idx),
      .o_any   (w_any)
   );

   always_comb begin
      w_web   = '0;
      w_addr  = '0;
      w_bt    = '0;
      w_wdata = '0;
      if (w_beat) begin
         w_web   = bus.web_i[r_own];
         w_addr  = bus.addr_i[r_own];
         w_bt    = bus.byte_type_i[r_own];
         w_wdata = bus.wdata_i[r_own];
      end
   end

   always_comb begin
      w_rvalid           = '0;
      w_rvalid[r_rd_tag] = r_rd_pend;
   end

   assign bus.glb_en_o        = w_beat;
   assign bus.glb_web_o       = w_web;
   assign bus.glb_addr_o      = w_addr;
   assign bus.glb_byte_type_o = w_bt;
   assign bus.glb_wdata_o     = w_wdata;
   assign bus.gnt_o           = r_gnt;
   assign bus.busy_o          = (r_state == BURST);
   assign bus.rvalid_o        = w_rvalid;
   assign bus.rdata_o         = bus.glb_rdata_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_own     <= '0;
         r_rr_ptr  <= '0;
         r_rd_tag  <= '0;
         r_gnt     <= '0;
         r_rd_pend <= 1'b0;
      end else begin
         r_rd_pend <= w_beat && (w_web == 4'b0000);
         if (w_beat) r_rd_tag <= r_own;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_state <= BURST;
                  r_own   <= w_pick_idx;
                  r_gnt   <= w_pick_gnt;
               end
            end
            BURST: begin
               if (w_beat && bus.last_i[r_own]) begin
                  r_rr_ptr <= w_own_nxt;
                  if (w_any) begin
                     r_own <= w_pick_idx;
                     r_gnt <= w_pick_gnt;
                  end else begin
                     r_state <= IDLE;
                     r_gnt   <= '0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef GLB_ARB_PERF_EN
   logic [NUM_REQ-1:0][15:0] r_wait;
   logic [NUM_REQ-1:0][15:0] r_beat_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wait     <= '0;
         r_beat_cnt <= '0;
      end else if (perf_clr_i) begin
         r_wait     <= '0;
         r_beat_cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (bus.req_i[PTR_W'(k)] && !r_gnt[PTR_W'(k)] && (r_wait[k] != 16'hFFFF))
               r_wait[k] <= r_wait[k] + 16'd1;
            if (w_beat && (r_own == PTR_W'(k)) && (r_beat_cnt[k] != 16'hFFFF))
               r_beat_cnt[k] <= r_beat_cnt[k] + 16'd1;
         end
      end
   end

   assign perf_wait_o = r_wait;
   assign perf_beat_o = r_beat_cnt;
`endif
endmodule

// File: tb/tb_glb_port_arbiter.sv
// tb/tb_glb_port_arbiter.sv - self-checking bench for glb_port_arbiter against a burst-level reference model
module tb_glb_port_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   glb_port_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bif ();

`ifdef GLB_ARB_PERF_EN
   logic               perf_clr = 1'b0;
   logic [N-1:0][15:0] perf_wait;
   logic [N-1:0][15:0] perf_beat;
`endif

   glb_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
`ifdef GLB_ARB_PERF_EN
      ,
      .perf_clr_i  (perf_clr),
      .perf_wait_o (perf_wait),
      .perf_beat_o (perf_beat)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // requester agents: each one walks a burst of len beats, optionally repeated
   int          rem [N];
   int          idx [N];
   int          len [N];
   int          rep [N];
   logic [31:0] base[N];
   logic [31:0] wd  [N];
   logic [3:0]  wb  [N];
   logic [1:0]  bt  [N];
   bit          stall[N];
   bit          do_clr = 1'b0;

   // reference model: owner (-1 = none), rotation start, expected read-return tag
   int          m_own = -1;
   int          m_rr  = 0;
   int          m_tag = -1;
   logic [15:0] m_wait[N];
   logic [15:0] m_beat[N];

   int          cyc = 0, n_en = 0, n_rv0 = 0, n_rv = 0, first_en = -1, last_en = -1;
   int          order[$];
   logic [N-1:0] prev_gnt = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int s);
      for (int i = 0; i < N; i++) begin
         if (r[(s + i) % N]) return (s + i) % N;
      end
      return -1;
   endfunction

   task automatic start(input int k, input int l, input logic [31:0] b, input logic [3:0] w,
                        input logic [31:0] d, input int reps);
      len[k] = l; rem[k] = l; idx[k] = 0; rep[k] = reps - 1;
      base[k] = b; wb[k] = w; wd[k] = d; bt[k] = 2'($urandom);
   endtask

   task automatic clear_agents();
      for (int k = 0; k < N; k++) begin
         rem[k] = 0; idx[k] = 0; rep[k] = 0; stall[k] = 1'b0;
         base[k] = '0; wd[k] = '0; wb[k] = '0; bt[k] = '0; len[k] = 0;
      end
   endtask

   task automatic drive();
      for (int k = 0; k < N; k++) begin
         bif.req_i[k]       = (rem[k] > 0) && !stall[k];
         bif.last_i[k]      = (rem[k] == 1);
         bif.web_i[k]       = wb[k];
         bif.addr_i[k]      = base[k] + 32'(idx[k]);
         bif.byte_type_i[k] = bt[k];
         bif.wdata_i[k]     = wd[k] + 32'(idx[k]);
      end
      bif.glb_rdata_i = $urandom;
`ifdef GLB_ARB_PERF_EN
      perf_clr = do_clr;
`endif
   endtask

   task automatic model_reset();
      m_own = -1; m_rr = 0; m_tag = -1;
      for (int k = 0; k < N; k++) begin m_wait[k] = '0; m_beat[k] = '0; end
   endtask

   task automatic check_outputs();
      logic [N-1:0]  eg, er;
      logic [3:0]    ew;
      logic [31:0]   ea, ed;
      logic [1:0]    eb;
      bit            beat;
      eg = '0; er = '0; ew = '0; ea = '0; ed = '0; eb = '0; beat = 1'b0;
      if (m_own >= 0) begin
         eg[m_own] = 1'b1;
         beat = bif.req_i[m_own];
         if (beat) begin
            ew = bif.web_i[m_own]; ea = bif.addr_i[m_own];
            ed = bif.wdata_i[m_own]; eb = bif.byte_type_i[m_own];
         end
      end
      if (m_tag >= 0) er[m_tag] = 1'b1;
      chk("gnt", 64'(bif.gnt_o), 64'(eg));
      chk("busy", 64'(bif.busy_o), 64'(m_own >= 0));
      chk("glb_en", 64'(bif.glb_en_o), 64'(beat));
      chk("glb_web", 64'(bif.glb_web_o), 64'(ew));
      chk("glb_addr", 64'(bif.glb_addr_o), 64'(ea));
      chk("glb_byte_type", 64'(bif.glb_byte_type_o), 64'(eb));
      chk("glb_wdata", 64'(bif.glb_wdata_o), 64'(ed));
      chk("rvalid", 64'(bif.rvalid_o), 64'(er));
      chk("rdata", 64'(bif.rdata_o), 64'(bif.glb_rdata_i));
`ifdef GLB_ARB_PERF_EN
      for (int k = 0; k < N; k++) begin
         chk("perf_wait", 64'(perf_wait[k]), 64'(m_wait[k]));
         chk("perf_beat", 64'(perf_beat[k]), 64'(m_beat[k]));
      end
`endif
   endtask

   // advance the model (and the owning agent) across the coming clock edge
   task automatic model_step();
      logic [N-1:0] r;
      int           o;
      bit           beat;
      r = bif.req_i; o = m_own;
      beat = (o >= 0) && r[o];
      if (do_clr) begin
         for (int k = 0; k < N; k++) begin m_wait[k] = '0; m_beat[k] = '0; end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (r[k] && (o != k) && m_wait[k] != 16'hFFFF) m_wait[k]++;
            if (beat && (o == k) && m_beat[k] != 16'hFFFF) m_beat[k]++;
         end
      end
      m_tag = -1;
      if (o < 0) begin
         m_own = pick(r, m_rr);
      end else if (beat) begin
         if (bif.web_i[o] == 4'b0000) m_tag = o;
         idx[o]++; rem[o]--;
         if (rem[o] == 0 && rep[o] > 0) begin rep[o]--; rem[o] = len[o]; idx[o] = 0; end
         if (bif.last_i[o]) begin
            m_rr = (o + 1) % N;
            r[o] = 1'b0;
            m_own = pick(r, m_rr);
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      drive();
      #2;
      check_outputs();
      model_step();
      cyc++;
      if (bif.glb_en_o) begin
         n_en++;
         if (first_en < 0) first_en = cyc;
         last_en = cyc;
      end
      if (bif.rvalid_o[0]) n_rv0++;
      if (|bif.rvalid_o) n_rv++;
      if (bif.gnt_o != prev_gnt && bif.gnt_o != '0) begin
         for (int k = 0; k < N; k++) if (bif.gnt_o[k]) order.push_back(k);
      end
      prev_gnt = bif.gnt_o;
   endtask

   // entered just after a cycle() check; rst rises before the next clock edge
   task automatic do_reset();
      #1 rst = 1'b1;
      model_reset();
      #1 check_outputs();
      clear_agents();
      prev_gnt = '0;
      @(negedge clk);
      drive();
      #2 check_outputs();
      #1 rst = 1'b0;
      model_step();
   endtask

   function automatic bit agents_busy();
      for (int k = 0; k < N; k++) if (rem[k] > 0) return 1'b1;
      return m_own >= 0;
   endfunction

   task automatic run_until_idle(input int bound);
      for (int c = 0; c < bound && agents_busy(); c++) cycle();
      cycle();
      chk("drain_busy", 64'(bif.busy_o), 64'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_agents();
      model_reset();
      drive();
      @(negedge clk);
      drive();
      #2 check_outputs();
      #1 rst = 1'b0;
      model_step();

      // weight 4-beat read burst at 0x100..0x103
      n_en = 0; n_rv0 = 0;
      start(0, 4, 32'h100, 4'h0, 32'h0, 1);
      run_until_idle(40);
      chk("t1_beats", 64'(n_en), 64'(4));
      chk("t1_rvalid0", 64'(n_rv0), 64'(4));

      // four requesters, 2-beat bursts back to back
      do_reset();
      order.delete(); n_en = 0; first_en = -1;
      start(0, 2, 32'h200, 4'h0, 32'h0, 2);
      start(1, 2, 32'h300, 4'h0, 32'h0, 1);
      start(2, 2, 32'h400, 4'h3, 32'h1111, 1);
      start(3, 2, 32'h500, 4'h0, 32'h0, 1);
      run_until_idle(60);
      begin
         int exp2[5];
         exp2 = '{0, 1, 2, 3, 0};
         chk("t2_nbursts", 64'(order.size()), 64'(5));
         for (int i = 0; i < 5 && i < order.size(); i++) chk("t2_order", 64'(order[i]), 64'(exp2[i]));
      end
      chk("t2_beats", 64'(n_en), 64'(10));
      chk("t2_span", 64'(last_en - first_en + 1), 64'(10));

      // ifmap stalls 3 cycles mid-burst
      start(1, 6, 32'h600, 4'h0, 32'h0, 1);
      for (int c = 0; c < 20 && idx[1] < 2; c++) cycle();
      stall[1] = 1'b1;
      order.delete();
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("t3_gnt", 64'(bif.gnt_o), 64'(4'b0010));
         chk("t3_en", 64'(bif.glb_en_o), 64'(0));
      end
      stall[1] = 1'b0;
      run_until_idle(30);
      chk("t3_rearb", 64'(order.size()), 64'(0));

      // opsum write burst
      start(3, 3, 32'h700, 4'hF, 32'hDEADBEEF, 1);
      n_rv = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (bif.glb_en_o) break;
      end
      chk("t4_wdata", 64'(bif.glb_wdata_o), 64'(32'hDEADBEEF));
      chk("t4_web", 64'(bif.glb_web_o), 64'(4'hF));
      run_until_idle(20);
      chk("t4_rvalid", 64'(n_rv), 64'(0));

      // reset during a read beat, then 2 and 1 together
      start(0, 4, 32'h800, 4'h0, 32'h0, 1);
      for (int c = 0; c < 10; c++) begin
         cycle();
         if (bif.glb_en_o) break;
      end
      do_reset();
      order.delete();
      start(2, 1, 32'h900, 4'h0, 32'h0, 1);
      start(1, 1, 32'hA00, 4'h0, 32'h0, 1);
      run_until_idle(20);
      chk("t5_nbursts", 64'(order.size()), 64'(2));
      if (order.size() >= 2) begin
         chk("t5_first", 64'(order[0]), 64'(1));
         chk("t5_second", 64'(order[1]), 64'(2));
      end

      // random bursts with random stalls
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++) begin
            if (rem[k] == 0 && ($urandom % 3) == 0)
               start(k, 1 + int'($urandom % 4), $urandom,
                     (($urandom % 2) == 0) ? 4'h0 : 4'($urandom), $urandom, 1);
            stall[k] = (($urandom % 5) == 0);
         end
         cycle();
      end
      for (int k = 0; k < N; k++) stall[k] = 1'b0;
      run_until_idle(200);

`ifdef GLB_ARB_PERF_EN
      do_reset();
      start(0, 4, 32'h100, 4'h0, 32'h0, 1);
      start(3, 1, 32'h200, 4'h0, 32'h0, 1);
      run_until_idle(30);
      chk("perf_wait3", 64'(perf_wait[3]), 64'(5));
      chk("perf_beat0", 64'(perf_beat[0]), 64'(4));
      do_clr = 1'b1;
      cycle();
      do_clr = 1'b0;
      cycle();
      for (int k = 0; k < N; k++) begin
         chk("perf_clr_wait", 64'(perf_wait[k]), 64'(0));
         chk("perf_clr_beat", 64'(perf_beat[k]), 64'(0));
      end
      start(0, 2, 32'h300, 4'h0, 32'h0, 1);
      cycle();
      stall[0] = 1'b1;
      start(3, 1, 32'h400, 4'h0, 32'h0, 1);
      for (int c = 0; c < 65540; c++) cycle();
      chk("perf_sat", 64'(perf_wait[3]), 64'(16'hFFFF));
      stall[0] = 1'b0;
      run_until_idle(30);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/glb_port_arbiter.md
# glb_port_arbiter

Shares the single GLB SRAM port among the token engine's load/store controllers: weight load, ifmap load, ipsum load and opsum store. It grants one requester at a time for a whole burst, using round-robin across bursts. It muxes that requester's address, WEB, byte-type and write data onto the GLB. It returns read data with a per-requester valid one cycle after each read beat.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (index 0 weight, 1 ifmap, 2 ipsum, 3 opsum)
- ADDR_W, 32, GLB byte address width
- DATA_W, 32, GLB data width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  [NUM_REQ]  requester wants a beat this cycle
- last_i  in  [NUM_REQ]  current beat is the final beat of the burst
- web_i  in  [NUM_REQ][4]  per-byte write enable; 4'b0000 means read
- addr_i  in  [NUM_REQ][ADDR_W]  byte address
- byte_type_i  in  [NUM_REQ][2]  LOAD_1BYTE..LOAD_4BYTE
- wdata_i  in  [NUM_REQ][DATA_W]  write data
- gnt_o  out  [NUM_REQ]  one-hot burst ownership (registered)
- rvalid_o  out  [NUM_REQ]  read data valid for that requester
- rdata_o  out  DATA_W  read data, broadcast to all requesters
- glb_en_o  out  1  GLB chip enable (beat this cycle)
- glb_web_o  out  4  to GLB
- glb_addr_o  out  ADDR_W  to GLB
- glb_byte_type_o  out  2  to GLB
- glb_wdata_o  out  DATA_W  to GLB
- glb_rdata_i  in  DATA_W  GLB read data; valid 1 cycle after a read beat
- busy_o  out  1  a burst is currently owned

## Operation
- FSM states:
  - IDLE: no owner.
  - BURST: owner index `own` held in a register.
- IDLE behaviour: if any req_i is set, pick a winner by round-robin, starting from index rr_ptr. Load gnt_o and `own`, then go to BURST. No beat occurs in this cycle.
- Beat definition: a beat occurs when state is BURST and req_i[own] is 1. glb_en_o is 1 only on a beat. The glb_* outputs are a combinational mux of the owner's inputs.
- When no beat occurs, the outputs are glb_en_o=0, glb_web_o=0 and glb_addr_o=0.
- Stall: if the owner drops req_i mid-burst, the grant is kept and no beat is issued.
- Burst end: the burst ends on a beat with last_i[own]=1.
  - rr_ptr becomes own+1, wrapping modulo NUM_REQ.
  - If another request is pending in that cycle, re-arbitrate from the new rr_ptr and load the new owner for the next cycle. The result is back-to-back bursts with no idle cycle.
  - Otherwise, go to IDLE with gnt_o=0.
- Same requester again: the same requester may win again only if no other request is pending.
- Read return: on a beat with glb_web_o==0, rd_tag<=own and rd_pend<=1. The next cycle, rvalid_o[rd_tag]=rd_pend and rdata_o=glb_rdata_i (pass-through).
- No rvalid is generated for a write beat.
- A read return may overlap the first beat of the next owner.

## Timing
- Latency:
  - Request to grant: 1 cycle (req_i in cycle N, gnt_o in N+1).
  - First beat: earliest in N+1.
  - Read data: rvalid_o is high 1 cycle after the read beat.
- Reset values:
  - gnt_o=0, rvalid_o=0, busy_o=0, glb_en_o=0, glb_web_o=0, glb_addr_o=0, glb_byte_type_o=0, glb_wdata_o=0, rdata_o=glb_rdata_i.
  - Internally: state=IDLE, rr_ptr=0, rd_pend=0.
- Reset mid-burst:
  - The burst is aborted immediately and any pending rvalid is dropped.
  - After reset, arbitration restarts from index 0.
- Single-beat bursts (req with last=1 on the first beat) are legal.
- rr_ptr width is $clog2(NUM_REQ).
- Inputs from non-owners are ignored.

## Configuration
- Macro GLB_ARB_PERF_EN, defined: adds the following ports.
  - perf_clr_i (in, 1)
  - perf_wait_o (out, [NUM_REQ][16]): counts cycles with req_i[k]=1 and gnt_o[k]=0.
  - perf_beat_o (out, [NUM_REQ][16]): counts beats of requester k.
  - Both counters saturate at 16'hFFFF.
  - perf_clr_i (synchronous) clears them to 0, and it takes priority over counting in the same cycle.
  - Both counters reset to 0.
- Macro not defined: the perf ports and counters do not exist, and the arbitration behaviour is identical.

## Structure
- Package glb_arb_pkg holds the following:
  - State enum {IDLE, BURST}.
  - REQ_WEIGHT=0, REQ_IFMAP=1, REQ_IPSUM=2, REQ_OPSUM=3.
  - The LOAD_1BYTE..LOAD_4BYTE codes.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, start pointer.
  - Outputs: one-hot grant, encoded index, any.
  - It is used in both the IDLE and burst-end arbitration.

## Test plan
- Reset, then weight requests a 4-beat read burst at addr 0x100..0x103:
  - gnt_o=0001 in cycle 1.
  - glb_en_o is high for 4 cycles.
  - rvalid_o[0] pulses 4 times, each 1 cycle after its beat.
  - After last, gnt_o=0 and busy_o=0.
- All 4 requesters request continuously with 2-beat bursts:
  - Grant order is 0,1,2,3,0.
  - There are no idle cycles between bursts.
- Owner ifmap deasserts req_i for 3 cycles mid-burst:
  - gnt_o stays 0010.
  - glb_en_o=0 for those 3 cycles.
  - The burst resumes without re-arbitration.
- Opsum write burst with web_i=4'b1111 and data 0xDEADBEEF:
  - glb_wdata_o=0xDEADBEEF and glb_web_o=1111.
  - No rvalid_o is generated.
- Assert rst mid-burst during a read beat:
  - All outputs are 0 the next cycle and no rvalid is generated.
  - A subsequent simultaneous req from 2 and 1 grants 1 first (rr_ptr=0).
- With GLB_ARB_PERF_EN, requester 3 waits 5 cycles behind a burst of 0:
  - perf_wait_o[3]=5.
  - perf_clr_i zeroes all counters.
  - Forcing perf_wait_o[k] near 16'hFFFF shows it saturates at 16'hFFFF.
